lock_access_controller: RTL and testbench

//   Front-end sequencer for the 4-digit combination lock core. Debounces the raw

---
 rtl/lock_access_controller.sv | 145 ++++++++++++++
 tb/tb_lock_access_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_access_controller.sv
// Front-end sequencer for the 4-digit combination lock core.
// Debounces the enter/lock buttons, strobes the core, counts consecutive wrong
// digits and enforces a timed lockout with alarm after too many failures.
module lock_access_controller #(
   parameter int unsigned DEBOUNCE_CYC = 16,
   parameter int unsigned MAX_FAIL     = 3,
   parameter int unsigned LOCKOUT_CYC  = 1000,
   localparam int unsigned FAIL_W      = $clog2(MAX_FAIL + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enter_btn,
   input  logic              lock_btn,
   input  logic [2:0]        core_state,
   input  logic              door_open,
   output logic              enter_pulse,
   output logic              lock_pulse,
   output logic [FAIL_W-1:0] fail_count,
   output logic              locked_out,
   output logic              alarm
);

   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC);
   localparam int unsigned TMR_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

   typedef enum logic [1:0] {StIdle, StPulse, StCheck, StLockout} state_e;

   // Index 0 = enter button, index 1 = lock button.
   logic [1:0]      btn_raw;
   logic [1:0]      sync1_q, sync2_q;
   logic [1:0]      level_q, level_prev_q;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [1:0]      req;
   logic            enter_req, lock_req;

   logic            lock_pulse_q;
   logic            door_q;
   logic            door_rise;

   state_e             state_q;
   logic               enter_pulse_q;
   logic [FAIL_W-1:0]  fail_q;
   logic [FAIL_W-1:0]  fail_inc;
   logic [TMR_W-1:0]   timer_q;
   logic               locked_q;
   logic               alarm_q;

   assign btn_raw   = {lock_btn, enter_btn};
   assign req       = level_q & ~level_prev_q;
   assign enter_req = req[0];
   assign lock_req  = req[1];
   assign door_rise = door_open & ~door_q;
   assign fail_inc  = (fail_q == FAIL_W'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;

   // Synchronise both buttons, debounce them and keep the previous level for edge detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         level_q      <= '0;
         level_prev_q <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         level_prev_q <= level_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == level_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
               level_q[i]  <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Lock strobe is independent of the FSM; door_open history feeds the rise detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_pulse_q <= 1'b0;
         door_q       <= 1'b0;
      end else begin
         lock_pulse_q <= lock_req;
         door_q       <= door_open;
      end
   end

   // Entry sequencer: strobe, evaluate core result, count failures, time the lockout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         enter_pulse_q <= 1'b0;
         fail_q        <= '0;
         timer_q       <= '0;
         locked_q      <= 1'b0;
         alarm_q       <= 1'b0;
      end else begin
         enter_pulse_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (enter_req) begin
                  state_q       <= StPulse;
                  enter_pulse_q <= 1'b1;
               end
            end
            StPulse: state_q <= StCheck;
            StCheck: begin
               state_q <= StIdle;
               // A same-cycle door opening wins over counting this digit as wrong.
               if (!door_rise && core_state == 3'd0) begin
                  fail_q <= fail_inc;
                  if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                     state_q  <= StLockout;
                     timer_q  <= TMR_W'(LOCKOUT_CYC - 1);
                     locked_q <= 1'b1;
                     alarm_q  <= 1'b1;
                  end
               end
            end
            StLockout: begin
               if (timer_q == '0) begin
                  state_q  <= StIdle;
                  fail_q   <= '0;
                  locked_q <= 1'b0;
                  alarm_q  <= 1'b0;
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
         if (door_rise && state_q != StLockout) fail_q <= '0;
      end
   end

   assign enter_pulse = enter_pulse_q;
   assign lock_pulse  = lock_pulse_q;
   assign fail_count  = fail_q;
   assign locked_out  = locked_q;
   assign alarm       = alarm_q;

endmodule

// File: tb/tb_lock_access_controller.sv
// Scoreboard bench for lock_access_controller: each enter press that should
// reach the core pushes the expected fail_count/locked_out; the monitor pops it
// two cycles after the observed enter_pulse.
module tb_lock_access_controller;

   localparam int unsigned DEBOUNCE_CYC = 4;
   localparam int unsigned MAX_FAIL     = 3;
   localparam int unsigned LOCKOUT_CYC  = 20;

   logic       clk;
   logic       rst_n;
   logic       enter_btn;
   logic       lock_btn;
   logic [2:0] core_state;
   logic       door_open;
   logic       enter_pulse;
   logic       lock_pulse;
   logic [1:0] fail_count;
   logic       locked_out;
   logic       alarm;

   typedef struct {
      int fail;
      int lock;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   mdl_fail = 0;
   int   exp_lock = 0;
   int   pulse_cnt = 0;
   int   lock_cnt  = 0;

   lock_access_controller #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .MAX_FAIL    (MAX_FAIL),
      .LOCKOUT_CYC (LOCKOUT_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enter_btn  (enter_btn),
      .lock_btn   (lock_btn),
      .core_state (core_state),
      .door_open  (door_open),
      .enter_pulse(enter_pulse),
      .lock_pulse (lock_pulse),
      .fail_count (fail_count),
      .locked_out (locked_out),
      .alarm      (alarm)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Model the core's reaction for the next press and queue the expected outcome.
   task automatic push_exp(input logic [2:0] cs);
      exp_t e;
      core_state = cs;
      if (cs == 3'd0 && mdl_fail < MAX_FAIL) mdl_fail++;
      e.fail = mdl_fail;
      e.lock = (mdl_fail == MAX_FAIL) ? 1 : 0;
      exp_q.push_back(e);
      if (e.lock == 1) mdl_fail = 0;
   endtask

   task automatic press(input int hold, input int post);
      enter_btn = 1'b1;
      repeat (hold) @(posedge clk);
      #1 enter_btn = 1'b0;
      repeat (post) @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard pops, pulse counting, lockout window length.
   initial begin
      int   dly;
      int   lo_run;
      int   al_run;
      exp_t cur;
      dly    = 0;
      lo_run = 0;
      al_run = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            dly    = 0;
            lo_run = 0;
            al_run = 0;
         end else begin
            if (dly > 0) begin
               dly--;
               if (dly == 0) begin
                  cur = exp_q.pop_front();
                  check("sb_fail_count", int'(fail_count), cur.fail);
                  check("sb_locked_out", int'(locked_out), cur.lock);
               end
            end
            if (enter_pulse) begin
               pulse_cnt++;
               if (exp_q.size() == 0) check("unexpected_enter_pulse", 1, 0);
               else dly = 2;
            end
            if (lock_pulse) lock_cnt++;
            if (locked_out) lo_run++;
            else if (lo_run > 0) begin
               check("lockout_len", lo_run, LOCKOUT_CYC);
               lo_run = 0;
            end
            if (alarm) al_run++;
            else if (al_run > 0) begin
               check("alarm_len", al_run, LOCKOUT_CYC);
               al_run = 0;
            end
         end
      end
   end

   initial begin
      int p0;
      rst_n      = 1'b0;
      enter_btn  = 1'b0;
      lock_btn   = 1'b0;
      core_state = 3'd1;
      door_open  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_enter_pulse", int'(enter_pulse), 0);
      check("rst_lock_pulse", int'(lock_pulse), 0);
      check("rst_fail_count", int'(fail_count), 0);
      check("rst_locked_out", int'(locked_out), 0);
      check("rst_alarm", int'(alarm), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Short glitch is filtered; a proper press gives one strobe, core_state=1 is no failure.
      p0 = pulse_cnt;
      press(2, 12);
      check("glitch_no_pulse", pulse_cnt - p0, 0);
      push_exp(3'd1);
      press(10, 12);
      check("single_pulse", pulse_cnt - p0, 1);

      // Two failures, then door opening clears the count on the following edge.
      push_exp(3'd0);
      press(10, 12);
      push_exp(3'd0);
      press(10, 12);
      check("pre_door_fail", int'(fail_count), 2);
      door_open = 1'b1;
      @(negedge clk);
      check("door_before_edge", int'(fail_count), 2);
      @(posedge clk);
      #1;
      check("door_clear", int'(fail_count), 0);
      mdl_fail = 0;
      repeat (3) @(posedge clk);
      #1 door_open = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Three failures -> lockout; enter during window dropped, lock still strobes.
      p0 = pulse_cnt;
      push_exp(3'd0);
      press(10, 12);
      push_exp(3'd0);
      press(10, 12);
      push_exp(3'd0);
      press(10, 7);
      check("in_lockout", int'(locked_out), 1);
      check("alarm_on", int'(alarm), 1);
      lock_btn = 1'b1;
      exp_lock++;
      press(8, 0);
      lock_btn = 1'b0;
      check("still_locked", int'(locked_out), 1);
      repeat (30) @(posedge clk);
      #1;
      check("lockout_pulses", pulse_cnt - p0, 3);
      check("post_lockout_fail", int'(fail_count), 0);
      check("post_lockout_locked", int'(locked_out), 0);

      // Bouncing press settles to a single strobe.
      p0 = pulse_cnt;
      push_exp(3'd2);
      for (int i = 0; i < 6; i++) begin
         enter_btn = ~enter_btn;
         @(posedge clk);
         #1;
      end
      press(10, 12);
      check("bounce_single_pulse", pulse_cnt - p0, 1);

      // Reset in the fifth lockout cycle clears everything asynchronously.
      push_exp(3'd0);
      press(10, 12);
      push_exp(3'd0);
      press(10, 12);
      push_exp(3'd0);
      press(10, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_locked_out", int'(locked_out), 0);
      check("arst_alarm", int'(alarm), 0);
      check("arst_fail_count", int'(fail_count), 0);
      check("arst_enter_pulse", int'(enter_pulse), 0);
      check("arst_lock_pulse", int'(lock_pulse), 0);
      mdl_fail = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("after_rst_fail", int'(fail_count), 0);
      push_exp(3'd0);
      press(10, 12);
      push_exp(3'd3);
      press(10, 12);

      check("sb_drained", exp_q.size(), 0);
      check("lock_pulses", lock_cnt, exp_lock);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
